// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding and port ids.
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/mem_access_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on contention the port not served last wins.
module rr_pick2
  import mem_access_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  // req[0] is the core, req[1] the host, matching the port ids
  always_comb begin
    sel = PORT_CORE;
    if (req == 2'b11) begin
      sel = ~last;
    end else if (req[1]) begin
      sel = PORT_HOST;
    end else begin
      sel = PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates core and host-loader accesses onto a single data memory with a
// one-cycle registered read; one transaction in flight at a time.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int reg_width  = 12,
  parameter int rd_latency = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_hold,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [reg_width-1:0] c_addr,
  input  logic [reg_width-1:0] c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [reg_width-1:0] c_rdata,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [reg_width-1:0] h_addr,
  input  logic [reg_width-1:0] h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [reg_width-1:0] h_rdata,
  output logic [reg_width-1:0] mem_address,
  output logic [reg_width-1:0] mem_data,
  output logic                 mem_wren,
  input  logic [reg_width-1:0] mem_q,
  output logic                 busy,
  output logic                 owner
);

  if (rd_latency != 1) begin : g_bad_latency
    $error("mem_access_arbiter supports rd_latency == 1 only");
  end

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [reg_width-1:0] addr_q, addr_d;
  logic [reg_width-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 mem_wren_q, mem_wren_d;
  logic                 c_gnt_q, c_gnt_d;
  logic                 h_gnt_q, h_gnt_d;
  logic                 c_rvalid_q, c_rvalid_d;
  logic                 h_rvalid_q, h_rvalid_d;
  logic [reg_width-1:0] c_rdata_q, c_rdata_d;
  logic [reg_width-1:0] h_rdata_q, h_rdata_d;

  logic [1:0] eligible_s;
  logic       sel_s;

  assign eligible_s = {h_req, c_req & ~host_hold};

  // rr_ptr_q names the port with priority; the picker wants the last-served one
  rr_pick2 u_rr_pick2 (
    .req  (eligible_s),
    .last (~rr_ptr_q),
    .sel  (sel_s)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    mem_wren_d = 1'b0;
    c_gnt_d    = 1'b0;
    h_gnt_d    = 1'b0;
    c_rvalid_d = 1'b0;
    h_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    h_rdata_d  = h_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d  = ST_ACCESS;
          owner_d  = sel_s;
          rr_ptr_d = ~sel_s;
          if (sel_s == PORT_HOST) begin
            addr_d     = h_addr;
            wdata_d    = h_wdata;
            we_d       = h_we;
            mem_wren_d = h_we;
            h_gnt_d    = 1'b1;
          end else begin
            addr_d     = c_addr;
            wdata_d    = c_wdata;
            we_d       = c_we;
            mem_wren_d = c_we;
            c_gnt_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        state_d = ST_IDLE;
        if (owner_q == PORT_HOST) begin
          h_rdata_d  = mem_q;
          h_rvalid_d = 1'b1;
        end else begin
          c_rdata_d  = mem_q;
          c_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= PORT_CORE;
      rr_ptr_q   <= PORT_CORE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_wren_q <= 1'b0;
      c_gnt_q    <= 1'b0;
      h_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      mem_wren_q <= mem_wren_d;
      c_gnt_q    <= c_gnt_d;
      h_gnt_q    <= h_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      h_rdata_q  <= h_rdata_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign mem_wren    = mem_wren_q;
  assign c_gnt       = c_gnt_q;
  assign h_gnt       = h_gnt_q;
  assign c_rvalid    = c_rvalid_q;
  assign h_rvalid    = h_rvalid_q;
  assign c_rdata     = c_rdata_q;
  assign h_rdata     = h_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural one-cycle data memory.
module tb_mem_access_arbiter;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         host_hold;
  logic         c_req, c_we, h_req, h_we;
  logic [W-1:0] c_addr, c_wdata, h_addr, h_wdata;
  logic         c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [W-1:0] c_rdata, h_rdata;
  logic [W-1:0] mem_address, mem_data, mem_q;
  logic         mem_wren, busy, owner;

  logic [W-1:0] mem_arr [0:4095];
  logic [W-1:0] exp_mem [0:4095];
  logic [W-1:0] cq [$];
  logic [W-1:0] hq [$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.reg_width(W), .rd_latency(1)) dut (
    .clk(clk), .reset(reset), .host_hold(host_hold),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  always @(posedge clk) begin
    if (mem_wren) mem_arr[mem_address] <= mem_data;
    mem_q <= mem_arr[mem_address];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (c_rvalid) begin
        if (cq.size() == 0) check_val("c_rvalid_unexpected", 32'd1, 32'd0);
        else check_val("c_rdata", {20'd0, c_rdata}, {20'd0, cq.pop_front()});
      end
      if (h_rvalid) begin
        if (hq.size() == 0) check_val("h_rvalid_unexpected", 32'd1, 32'd0);
        else check_val("h_rdata", {20'd0, h_rdata}, {20'd0, hq.pop_front()});
      end
      check_val("gnt_exclusive", {31'd0, c_gnt & h_gnt}, 32'd0);
      check_val("wren_only_busy", {31'd0, mem_wren & ~busy}, 32'd0);
    end
  end

  task automatic idle_inputs();
    host_hold = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // single request on one port, released once granted
  task automatic issue(input bit port, input bit we, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata);
    int n;
    if (!we) begin
      if (port) hq.push_back(exp_mem[addr]);
      else cq.push_back(exp_mem[addr]);
    end else begin
      exp_mem[addr] = wdata;
    end
    if (port) begin h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata; end
    else begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? h_gnt : c_gnt) && n < 20);
    if (n >= 20) check_val("issue_gnt_timeout", 32'd0, 32'd1);
    c_req = 1'b0;
    h_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cq.size() != 0 || hq.size() != 0 || busy || c_rvalid || h_rvalid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val("drain_pending", cq.size() + hq.size(), 32'd0);
  endtask

  initial begin
    int n, k, t1, t2, gcnt, c_cnt, h_cnt;
    int order [2];
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_gnt", {30'd0, c_gnt, h_gnt}, 32'd0);
    check_val("rst_wren", {31'd0, mem_wren}, 32'd0);
    do_reset();
    mon_en = 1'b1;

    // core write 0x005 <- 0xABC, then read back
    exp_mem[12'h005] = 12'hABC;
    c_req = 1'b1; c_we = 1'b1; c_addr = 12'h005; c_wdata = 12'hABC;
    @(negedge clk);
    check_val("wr_c_gnt", {31'd0, c_gnt}, 32'd1);
    check_val("wr_h_gnt", {31'd0, h_gnt}, 32'd0);
    check_val("wr_wren", {31'd0, mem_wren}, 32'd1);
    check_val("wr_addr", {20'd0, mem_address}, 32'h005);
    check_val("wr_data", {20'd0, mem_data}, 32'hABC);
    check_val("wr_owner", {30'd0, busy, owner}, 32'd2);
    c_req = 1'b0;
    @(negedge clk);
    check_val("wr_gnt_1cyc", {31'd0, c_gnt}, 32'd0);
    check_val("wr_wren_1cyc", {31'd0, mem_wren}, 32'd0);
    check_val("wr_back_idle", {31'd0, busy}, 32'd0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h005;
    cq.push_back(12'hABC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (c_gnt) c_req = 1'b0;
    end while (!c_rvalid && n < 10);
    check_val("rd_latency", n, 32'd3);
    c_req = 1'b0;

    issue(1'b1, 1'b1, 12'h010, 12'h123);
    issue(1'b1, 1'b1, 12'h011, 12'h456);
    drain();

    // simultaneous reads right out of reset: core first
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h005; cq.push_back(12'hABC);
    h_req = 1'b1; h_we = 1'b0; h_addr = 12'h010; hq.push_back(12'h123);
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (c_gnt) begin c_req = 1'b0; order[k] = 0; k++; end
      if (h_gnt && k < 2) begin h_req = 1'b0; order[k] = 1; k++; end
    end
    check_val("rr_two_grants", k, 32'd2);
    check_val("rr_first_core", order[0], 32'd0);
    check_val("rr_second_host", order[1], 32'd1);
    drain();

    // host_hold: only host served while held
    exp_mem[12'h020] = 12'h777;
    host_hold = 1'b1;
    h_req = 1'b1; h_we = 1'b1; h_addr = 12'h020; h_wdata = 12'h777;
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h005; cq.push_back(12'hABC);
    c_cnt = 0; h_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (c_gnt) c_cnt++;
      if (h_gnt) h_cnt++;
    end
    check_val("hold_c_gnt", c_cnt, 32'd0);
    check_val("hold_h_gnt", h_cnt, 32'd6);
    host_hold = 1'b0;
    @(negedge clk);
    check_val("unhold_c_gnt", {31'd0, c_gnt}, 32'd1);
    check_val("unhold_h_gnt", {31'd0, h_gnt}, 32'd0);
    c_req = 1'b0; h_req = 1'b0;
    drain();
    issue(1'b0, 1'b0, 12'h020, 12'h000);
    drain();

    // host back-to-back reads, address changed after each grant
    h_req = 1'b1; h_we = 1'b0; h_addr = 12'h010; hq.push_back(12'h123);
    n = 0; t1 = -1; t2 = -1; gcnt = 0;
    while (t2 < 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (h_gnt) begin
        gcnt++;
        if (gcnt == 1) begin h_addr = 12'h011; hq.push_back(12'h456); end
        else h_req = 1'b0;
      end
      if (h_rvalid) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    h_req = 1'b0;
    check_val("b2b_first_rvalid", t1, 32'd3);
    check_val("b2b_spacing", t2 - t1, 32'd3);
    drain();

    // reset during READ_WAIT
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h005;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_gnt && n < 20);
    c_req = 1'b0;
    @(negedge clk);
    check_val("rw_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("arst_ctrl", {25'd0, c_gnt, h_gnt, c_rvalid, h_rvalid, mem_wren, busy, owner}, 32'd0);
    check_val("arst_c_rdata", {20'd0, c_rdata}, 32'd0);
    check_val("arst_h_rdata", {20'd0, h_rdata}, 32'd0);
    check_val("arst_mem_bus", {8'd0, mem_address, mem_data}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 12'h030; c_wdata = 12'h111;
    h_req = 1'b1; h_we = 1'b1; h_addr = 12'h031; h_wdata = 12'h222;
    exp_mem[12'h030] = 12'h111;
    exp_mem[12'h031] = 12'h222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_gnt && !h_gnt && n < 20);
    check_val("post_rst_core_first", {30'd0, c_gnt, h_gnt}, 32'd2);
    c_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!h_gnt && n < 20);
    check_val("post_rst_host_gnt", {31'd0, h_gnt}, 32'd1);
    h_req = 1'b0;
    issue(1'b1, 1'b0, 12'h030, 12'h000);
    issue(1'b0, 1'b0, 12'h031, 12'h000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
